// File: rtl/pipe_pkg.sv
// Shared fetch-stage types and constants.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC and IF/ID ownership, hazard hold/redirect/squash,
// ID/EX bubble request and stall/flush event counters.
module fetch_ctrl #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR   = pipe_pkg::NOP_INSTR,
  parameter int unsigned            COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  pc_target,
  input  logic [DATA_WIDTH-1:0]  imem_rdata,
  input  logic                   cnt_clear,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  output logic [DATA_WIDTH-1:0]  ifid_pc,
  output logic [DATA_WIDTH-1:0]  ifid_pc_plus_4,
  output logic [DATA_WIDTH-1:0]  ifid_instr,
  output logic                   ifid_valid,
  output logic                   idex_bubble,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  import pipe_pkg::*;

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_next;
  ifid_t                 r_ifid;
  ifid_t                 w_ifid_next;
  logic                  w_stall_inc;
  logic                  w_flush_inc;
  logic                  w_bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_ifid.pc    <= RESET_PC;
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ifid  <= w_ifid_next;
    end
  end

  always_comb begin
    w_state_next = RUN;
    w_pc_next    = r_pc;
    w_ifid_next  = r_ifid;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_bubble     = 1'b1;
    case (r_state)
      BOOT: begin
        // hazard requests are meaningless before the first fetch
        w_ifid_next.instr = NOP_INSTR;
        w_ifid_next.valid = 1'b0;
      end
      RUN: begin
        w_bubble = flush | stall | ~r_ifid.valid;
        if (flush) begin
          w_pc_next         = pc_target;
          w_ifid_next.pc    = r_pc;
          w_ifid_next.instr = NOP_INSTR;
          w_ifid_next.valid = 1'b0;
          w_flush_inc       = 1'b1;
        end else if (stall) begin
          w_stall_inc = 1'b1;
        end else begin
          w_pc_next         = r_pc + DATA_WIDTH'(4);
          w_ifid_next.pc    = r_pc;
          w_ifid_next.instr = imem_rdata;
          w_ifid_next.valid = 1'b1;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .clear (cnt_clear),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_inc),
    .clear (cnt_clear),
    .count (flush_count)
  );

  assign imem_addr      = r_pc;
  assign ifid_pc        = r_ifid.pc;
  assign ifid_pc_plus_4 = r_ifid.pc + DATA_WIDTH'(4);
  assign ifid_instr     = r_ifid.instr;
  assign ifid_valid     = r_ifid.valid;
  assign idex_bubble    = w_bubble;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: main 32-bit-counter instance plus a
// 4-bit-counter instance for saturation.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, cnt_clear;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_pc_plus_4, ifid_instr;
  logic        ifid_valid, idex_bubble;
  logic [31:0] stall_count, flush_count;

  logic        reset2, stall2, flush2, cnt_clear2;
  logic [31:0] pc_target2;
  logic [31:0] imem_addr2, imem_rdata2, ifid_pc2, ifid_pc_plus_42, ifid_instr2;
  logic        ifid_valid2, idex_bubble2;
  logic [3:0]  stall_count2, flush_count2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // instruction memory model: word = 0xA000_0000 | address
  assign imem_rdata  = 32'hA000_0000 | imem_addr;
  assign imem_rdata2 = 32'hA000_0000 | imem_addr2;

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_target(pc_target), .imem_rdata(imem_rdata), .cnt_clear(cnt_clear),
    .imem_addr(imem_addr), .ifid_pc(ifid_pc), .ifid_pc_plus_4(ifid_pc_plus_4),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .idex_bubble(idex_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  fetch_ctrl #(.COUNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset2), .stall(stall2), .flush(flush2),
    .pc_target(pc_target2), .imem_rdata(imem_rdata2), .cnt_clear(cnt_clear2),
    .imem_addr(imem_addr2), .ifid_pc(ifid_pc2), .ifid_pc_plus_4(ifid_pc_plus_42),
    .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2), .idex_bubble(idex_bubble2),
    .stall_count(stall_count2), .flush_count(flush_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] instr, input logic valid);
    chk({tag, ".ifid_pc"}, ifid_pc, pc);
    chk({tag, ".ifid_pc4"}, ifid_pc_plus_4, pc + 32'd4);
    chk({tag, ".ifid_instr"}, ifid_instr, instr);
    chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"}, imem_addr, 32'h0);
    chk_ifid(tag, 32'h0, NOP, 1'b0);
    chk({tag, ".bubble"}, {31'd0, idex_bubble}, 32'd1);
    chk({tag, ".scnt"}, stall_count, 32'd0);
    chk({tag, ".fcnt"}, flush_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clear = 1'b0; pc_target = '0;
    reset2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0; cnt_clear2 = 1'b0; pc_target2 = '0;
    #1;
    chk_reset_vals("rst");
    edge1();
    reset = 1'b0;
    chk("boot.bubble", {31'd0, idex_bubble}, 32'd1);

    // BOOT edge: ifid stays NOP, PC stays 0
    edge1();
    chk("run0.addr", imem_addr, 32'h0);
    chk_ifid("run0", 32'h0, NOP, 1'b0);
    chk("run0.bubble", {31'd0, idex_bubble}, 32'd1);

    edge1();
    chk_ifid("f0", 32'h0, 32'hA000_0000, 1'b1);
    chk("f0.addr", imem_addr, 32'h4);
    chk("f0.bubble", {31'd0, idex_bubble}, 32'd0);
    edge1();
    chk_ifid("f4", 32'h4, 32'hA000_0004, 1'b1);
    edge1();
    chk_ifid("f8", 32'h8, 32'hA000_0008, 1'b1);
    chk("f8.bubble", {31'd0, idex_bubble}, 32'd0);
    edge1();
    chk("fC.addr", imem_addr, 32'h10);

    // stall 3 cycles at PC=0x10
    stall = 1'b1;
    #1;
    chk("st.bubble0", {31'd0, idex_bubble}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("st.addr", imem_addr, 32'h10);
      chk_ifid("st", 32'hC, 32'hA000_000C, 1'b1);
      chk("st.bubble", {31'd0, idex_bubble}, 32'd1);
    end
    chk("st.scnt", stall_count, 32'd3);
    stall = 1'b0;
    #1;
    chk("st.bubble_off", {31'd0, idex_bubble}, 32'd0);
    edge1();
    chk_ifid("resume", 32'h10, 32'hA000_0010, 1'b1);
    chk("resume.addr", imem_addr, 32'h14);
    chk("resume.scnt", stall_count, 32'd3);
    edge1(); edge1(); edge1();
    chk("pre_fl.addr", imem_addr, 32'h20);

    // flush to 0x100 at PC=0x20
    flush = 1'b1; pc_target = 32'h100;
    #1;
    chk("fl.bubble0", {31'd0, idex_bubble}, 32'd1);
    edge1();
    flush = 1'b0; pc_target = 32'hDEAD_BEEF;
    chk("fl.addr", imem_addr, 32'h100);
    chk_ifid("fl", 32'h20, NOP, 1'b0);
    chk("fl.fcnt", flush_count, 32'd1);
    chk("fl.bubble1", {31'd0, idex_bubble}, 32'd1);
    edge1();
    chk_ifid("fl_tgt", 32'h100, 32'hA000_0100, 1'b1);
    chk("fl_tgt.addr", imem_addr, 32'h104);

    // simultaneous stall+flush: flush wins, stall not counted
    stall = 1'b1; flush = 1'b1; pc_target = 32'h40;
    edge1();
    stall = 1'b0; flush = 1'b0;
    chk("sf.addr", imem_addr, 32'h40);
    chk_ifid("sf", 32'h104, NOP, 1'b0);
    chk("sf.scnt", stall_count, 32'd3);
    chk("sf.fcnt", flush_count, 32'd2);
    edge1();
    chk_ifid("sf_tgt", 32'h40, 32'hA000_0040, 1'b1);

    // unaligned-free target near top of space, then wrap
    flush = 1'b1; pc_target = 32'hFFFF_FFFC;
    edge1();
    flush = 1'b0;
    chk("wr.addr0", imem_addr, 32'hFFFF_FFFC);
    edge1();
    chk("wr.addr", imem_addr, 32'h0);
    chk("wr.ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wr.ifid_pc4", ifid_pc_plus_4, 32'h0);
    chk("wr.instr", ifid_instr, 32'hFFFF_FFFC);

    cnt_clear = 1'b1;
    edge1();
    cnt_clear = 1'b0;
    chk("clr.scnt", stall_count, 32'd0);
    chk("clr.fcnt", flush_count, 32'd0);
    chk("clr.addr", imem_addr, 32'h4);

    // reset in the middle of a stall, between edges
    stall = 1'b1;
    edge1();
    chk("ms.scnt", stall_count, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("ms_rst");

    // BOOT ignores hazards
    flush = 1'b1; pc_target = 32'h80;
    edge1();
    reset = 1'b0;
    edge1();
    chk("boot_ign.addr", imem_addr, 32'h0);
    chk("boot_ign.scnt", stall_count, 32'd0);
    chk("boot_ign.fcnt", flush_count, 32'd0);
    chk_ifid("boot_ign", 32'h0, NOP, 1'b0);
    stall = 1'b0; flush = 1'b0;
    edge1();
    chk_ifid("boot_ign_f", 32'h0, 32'hA000_0000, 1'b1);

    // 4-bit counters: saturation and clear-over-increment
    reset2 = 1'b0;
    edge1();
    stall2 = 1'b1;
    for (int i = 0; i < 14; i++) edge1();
    chk("sat.14", {28'd0, stall_count2}, 32'd14);
    edge1();
    chk("sat.15", {28'd0, stall_count2}, 32'd15);
    for (int i = 0; i < 5; i++) edge1();
    chk("sat.hold", {28'd0, stall_count2}, 32'd15);
    chk("sat.addr", imem_addr2, 32'h0);
    cnt_clear2 = 1'b1;
    edge1();
    chk("sat.clr", {28'd0, stall_count2}, 32'd0);
    cnt_clear2 = 1'b0;
    edge1();
    chk("sat.after", {28'd0, stall_count2}, 32'd1);
    stall2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
